// File: rtl/tdc_lbus_regs.sv
// tdc_lbus_regs: TDC control/status register file on the local write/read bus
// (page 0x90xx, downstream of the TRBNet-to-local-bus translator).
//
// Ports:
//   Cclk, Reset           bus clock, synchronous active-high reset
//   Address, WData        local address and write data
//   Write, Read           single-cycle access strobes
//   RData                 registered read data (held while Read is low)
//   ctrl                  NCTRL flattened 32-bit control registers
//   pulse                 one-cycle command pulses (written via 0x10)
//   status_in             TDC status word, readable at 0x20
//   evt_strobe            event counter enable (0x21)
//   bad_addr              sticky unmapped-access flag, cleared by writing 0x23
//
// Optional feature: define TDC_LBUS_WRCNT_EN to build the write counter at 0x22.
module tdc_lbus_regs #(
  parameter int unsigned NCTRL = 8,
  parameter logic [31:0] ID    = 32'h9000_0001
) (
  input  logic                  Cclk,
  input  logic                  Reset,
  input  logic [7:0]            Address,
  input  logic [31:0]           WData,
  input  logic                  Write,
  input  logic                  Read,
  output logic [31:0]           RData,
  output logic [NCTRL*32-1:0]   ctrl,
  output logic [31:0]           pulse,
  input  logic [31:0]           status_in,
  input  logic                  evt_strobe,
  output logic                  bad_addr
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = NCTRL * DW;

  localparam logic [7:0] A_PULSE  = 8'h10;
  localparam logic [7:0] A_STATUS = 8'h20;
  localparam logic [7:0] A_EVT    = 8'h21;
  localparam logic [7:0] A_WRCNT  = 8'h22;
  localparam logic [7:0] A_ERR    = 8'h23;
  localparam logic [7:0] A_ID     = 8'h3F;
  localparam logic [7:0] A_NCTRL  = 8'(NCTRL);

  logic [DW-1:0] rdata_q,   rdata_d;
  logic [CW-1:0] ctrl_q,    ctrl_d;
  logic [DW-1:0] pulse_q,   pulse_d;
  logic [DW-1:0] status_q,  status_d;
  logic [DW-1:0] evt_cnt_q, evt_cnt_d;
  logic          bad_addr_q, bad_addr_d;

  logic [DW-1:0] rsel;
  logic          mapped;
  logic          evt_clr;

`ifdef TDC_LBUS_WRCNT_EN
  logic [DW-1:0] wr_cnt_q, wr_cnt_d;
`endif

  // Read mux and address decode
  always_comb begin
    rsel   = 32'hDEAD_BEEF;
    mapped = 1'b1;
    if (Address < A_NCTRL) begin
      for (int unsigned k = 0; k < NCTRL; k++) begin
        if (Address == 8'(k)) rsel = ctrl_q[DW*k +: DW];
      end
    end else begin
      case (Address)
        A_PULSE:  rsel = '0;
        A_STATUS: rsel = status_q;
        A_EVT:    rsel = evt_cnt_q;
`ifdef TDC_LBUS_WRCNT_EN
        A_WRCNT:  rsel = wr_cnt_q;
`endif
        A_ERR:    rsel = {31'b0, bad_addr_q};
        A_ID:     rsel = ID;
        default:  mapped = 1'b0;
      endcase
    end
  end

  // Next-state for all registers
  always_comb begin
    rdata_d    = Read ? rsel : rdata_q;
    ctrl_d     = ctrl_q;
    pulse_d    = '0;
    status_d   = status_in;
    bad_addr_d = bad_addr_q;

    for (int unsigned k = 0; k < NCTRL; k++) begin
      if (Write && Address == 8'(k)) ctrl_d[DW*k +: DW] = WData;
    end

    if (Write && Address == A_PULSE) pulse_d = WData;

    // Clear beats increment; the pulse-driven clear acts while pulse[0] is high
    evt_clr = (Write && Address == A_EVT) || pulse_q[0];
    if (evt_clr)
      evt_cnt_d = '0;
    else if (evt_strobe && evt_cnt_q != '1)
      evt_cnt_d = evt_cnt_q + DW'(1);
    else
      evt_cnt_d = evt_cnt_q;

    if (Write && Address == A_ERR)
      bad_addr_d = 1'b0;
    else if ((Read || Write) && !mapped)
      bad_addr_d = 1'b1;
  end

  always_ff @(posedge Cclk) begin
    if (Reset) begin
      rdata_q    <= '0;
      ctrl_q     <= '0;
      pulse_q    <= '0;
      status_q   <= '0;
      evt_cnt_q  <= '0;
      bad_addr_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      pulse_q    <= pulse_d;
      status_q   <= status_d;
      evt_cnt_q  <= evt_cnt_d;
      bad_addr_q <= bad_addr_d;
    end
  end

`ifdef TDC_LBUS_WRCNT_EN
  // Counts every write; a write to its own address zeroes it instead
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (Write) wr_cnt_d = (Address == A_WRCNT) ? '0 : wr_cnt_q + DW'(1);
  end

  always_ff @(posedge Cclk) begin
    if (Reset) wr_cnt_q <= '0;
    else       wr_cnt_q <= wr_cnt_d;
  end
`endif

  assign RData    = rdata_q;
  assign ctrl     = ctrl_q;
  assign pulse    = pulse_q;
  assign bad_addr = bad_addr_q;

endmodule

// File: tb/tb_tdc_lbus_regs.sv
// Testbench for tdc_lbus_regs: randomized bus traffic against a
// transaction-level reference model of the register map.
module tb_tdc_lbus_regs;

  localparam int unsigned NCTRL = 8;
  localparam logic [31:0] ID    = 32'h9000_0001;

  logic                  Cclk = 1'b0;
  logic                  Reset = 1'b0;
  logic [7:0]            Address = '0;
  logic [31:0]           WData = '0;
  logic                  Write = 1'b0;
  logic                  Read = 1'b0;
  logic [31:0]           RData;
  logic [NCTRL*32-1:0]   ctrl;
  logic [31:0]           pulse;
  logic [31:0]           status_in = '0;
  logic                  evt_strobe = 1'b0;
  logic                  bad_addr;

  tdc_lbus_regs #(.NCTRL(NCTRL), .ID(ID)) dut (
    .Cclk(Cclk), .Reset(Reset), .Address(Address), .WData(WData),
    .Write(Write), .Read(Read), .RData(RData), .ctrl(ctrl), .pulse(pulse),
    .status_in(status_in), .evt_strobe(evt_strobe), .bad_addr(bad_addr)
  );

  always #5 Cclk = ~Cclk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state (values visible after the most recent edge)
  logic [NCTRL*32-1:0] m_ctrl;
  logic [31:0] m_rdata, m_pulse, m_evt, m_status, m_wrcnt;
  logic        m_bad, m_pclr;
  logic [31:0] next_status = '0;

  function automatic bit m_mapped(input logic [7:0] a);
    if (int'(a) < NCTRL) return 1'b1;
    case (a)
      8'h10, 8'h20, 8'h21, 8'h23, 8'h3F: return 1'b1;
`ifdef TDC_LBUS_WRCNT_EN
      8'h22: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (int'(a) < NCTRL) return m_ctrl[32*int'(a) +: 32];
    case (a)
      8'h10: return 32'h0;
      8'h20: return m_status;
      8'h21: return m_evt;
`ifdef TDC_LBUS_WRCNT_EN
      8'h22: return m_wrcnt;
`endif
      8'h23: return {31'b0, m_bad};
      8'h3F: return ID;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // One bus cycle: drive at negedge, update model for the coming edge, return just after it
  task automatic cycle(input logic wr, input logic rd, input logic [7:0] a,
                       input logic [31:0] wd, input logic stb);
    @(negedge Cclk);
    Write = wr; Read = rd; Address = a; WData = wd; evt_strobe = stb;
    status_in = next_status;
    if (rd) m_rdata = m_read(a);
    if (wr && a == 8'h23) m_bad = 1'b0;
    else if ((wr || rd) && !m_mapped(a)) m_bad = 1'b1;
    if (m_pclr || (wr && a == 8'h21)) m_evt = 32'h0;
    else if (stb && m_evt != 32'hFFFF_FFFF) m_evt = m_evt + 32'd1;
    m_pclr  = wr && a == 8'h10 && wd[0];
    m_pulse = (wr && a == 8'h10) ? wd : 32'h0;
    if (wr && int'(a) < NCTRL) m_ctrl[32*int'(a) +: 32] = wd;
    if (wr) m_wrcnt = (a == 8'h22) ? 32'h0 : m_wrcnt + 32'd1;
    m_status = status_in;
    @(posedge Cclk); #1;
    Write = 1'b0; Read = 1'b0; evt_strobe = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Cclk);
      Reset = 1'b1; Write = 1'($urandom); Read = 1'($urandom);
      Address = 8'($urandom); WData = $urandom; evt_strobe = 1'b1;
      status_in = next_status;
      @(posedge Cclk); #1;
    end
    Reset = 1'b0; Write = 1'b0; Read = 1'b0; evt_strobe = 1'b0;
    m_ctrl = '0; m_rdata = '0; m_pulse = '0; m_evt = '0; m_status = '0;
    m_wrcnt = '0; m_bad = 1'b0; m_pclr = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0]  ra [4];
    logic [31:0] re [4];
    ra = '{8'h00, 8'h10, 8'h21, 8'h3F};
    re = '{32'h0, 32'h0, 32'h0, 32'h9000_0001};
    apply_reset(3);
    n_chk++; if (RData !== 32'h0) $display("FAIL reset_rdata: got %h want 0", RData); else n_pass++;
    n_chk++; if (pulse !== 32'h0) $display("FAIL reset_pulse: got %h want 0", pulse); else n_pass++;
    n_chk++; if (ctrl !== '0) $display("FAIL reset_ctrl: got %h want 0", ctrl); else n_pass++;
    n_chk++; if (bad_addr !== 1'b0) $display("FAIL reset_bad: got %b want 0", bad_addr); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, ra[i], 32'h0, 1'b0);
      n_chk++;
      if (RData !== re[i]) $display("FAIL reset_read_%h: got %h want %h", ra[i], RData, re[i]);
      else n_pass++;
    end
    n_chk++; if (bad_addr !== 1'b0) $display("FAIL reset_bad_after_reads: got %b want 0", bad_addr); else n_pass++;
  endtask

  task automatic test_ctrl();
    logic [7:0] a;
    logic [31:0] d;
    cycle(1'b1, 1'b0, 8'h05, 32'hA5A5_1234, 1'b0);
    n_chk++; if (ctrl[191:160] !== 32'hA5A5_1234) $display("FAIL ctrl5_out: got %h want a5a51234", ctrl[191:160]); else n_pass++;
    n_chk++; if (ctrl !== m_ctrl) $display("FAIL ctrl_neighbours: got %h want %h", ctrl, m_ctrl); else n_pass++;
    cycle(1'b0, 1'b1, 8'h05, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'hA5A5_1234) $display("FAIL ctrl5_read: got %h want a5a51234", RData); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, NCTRL - 1));
      d = $urandom;
      cycle(1'b1, 1'b0, a, d, 1'b0);
      cycle(1'b0, 1'b1, 8'($urandom_range(0, NCTRL - 1)), 32'h0, 1'b0);
      n_chk++; if (RData !== m_rdata) $display("FAIL ctrl_rand_read: got %h want %h", RData, m_rdata); else n_pass++;
      n_chk++; if (ctrl !== m_ctrl) $display("FAIL ctrl_rand_out: got %h want %h", ctrl, m_ctrl); else n_pass++;
    end
  endtask

  task automatic test_pulse();
    logic [31:0] d;
    cycle(1'b1, 1'b0, 8'h21, 32'h0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 8'h10, 32'h0000_0003, 1'b1);
    n_chk++; if (pulse !== 32'h3) $display("FAIL pulse_high: got %h want 3", pulse); else n_pass++;
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    n_chk++; if (pulse !== 32'h0) $display("FAIL pulse_low: got %h want 0", pulse); else n_pass++;
    cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'h0) $display("FAIL pulse_evt_clear: got %h want 0", RData); else n_pass++;
    cycle(1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'h0) $display("FAIL pulse_read_zero: got %h want 0", RData); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      repeat (2) cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      cycle(1'b1, 1'b0, 8'h10, d, 1'($urandom));
      n_chk++; if (pulse !== m_pulse) $display("FAIL pulse_rand_high: got %h want %h", pulse, m_pulse); else n_pass++;
      cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'b1);
      n_chk++; if (pulse !== 32'h0) $display("FAIL pulse_rand_low: got %h want 0", pulse); else n_pass++;
      cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
      n_chk++; if (RData !== m_rdata) $display("FAIL pulse_rand_evt: got %h want %h", RData, m_rdata); else n_pass++;
    end
  endtask

  task automatic test_counter();
    cycle(1'b1, 1'b0, 8'h21, 32'h0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'd10) $display("FAIL evt_count10: got %h want 0000000a", RData); else n_pass++;
    // Preload near saturation through the counter flop
    @(negedge Cclk);
    status_in = next_status;
    force dut.evt_cnt_q = 32'hFFFF_FFFE;
    @(posedge Cclk); #1;
    release dut.evt_cnt_q;
    m_evt = 32'hFFFF_FFFE;
    m_status = status_in;
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'hFFFF_FFFF) $display("FAIL evt_saturate: got %h want ffffffff", RData); else n_pass++;
    cycle(1'b1, 1'b0, 8'h21, 32'h1234, 1'b1);
    cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'h0) $display("FAIL evt_clear_wins: got %h want 0", RData); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      repeat (20) cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'($urandom));
      cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'($urandom));
      n_chk++; if (RData !== m_rdata) $display("FAIL evt_rand: got %h want %h", RData, m_rdata); else n_pass++;
    end
  endtask

  task automatic test_status();
    for (int i = 0; i < 6; i++) begin
      next_status = $urandom;
      cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 8'h20, $urandom, 1'b0);
      cycle(1'b0, 1'b1, 8'h20, 32'h0, 1'b0);
      n_chk++; if (RData !== next_status) $display("FAIL status_read: got %h want %h", RData, next_status); else n_pass++;
      n_chk++; if (bad_addr !== m_bad) $display("FAIL status_bad: got %b want %b", bad_addr, m_bad); else n_pass++;
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] a;
    logic rd;
    cycle(1'b0, 1'b1, 8'h55, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'hDEAD_BEEF) $display("FAIL unmapped_read: got %h want deadbeef", RData); else n_pass++;
    n_chk++; if (bad_addr !== 1'b1) $display("FAIL unmapped_bad_set: got %b want 1", bad_addr); else n_pass++;
    cycle(1'b0, 1'b1, 8'h23, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'h1) $display("FAIL err_read: got %h want 1", RData); else n_pass++;
    cycle(1'b1, 1'b0, 8'h23, 32'h0, 1'b0);
    n_chk++; if (bad_addr !== 1'b0) $display("FAIL err_clear: got %b want 0", bad_addr); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      while (m_mapped(a)) a = 8'($urandom);
      rd = 1'($urandom);
      cycle(!rd, rd, a, $urandom, 1'b0);
      n_chk++; if (bad_addr !== 1'b1) $display("FAIL unmapped_rand_bad %h: got %b want 1", a, bad_addr); else n_pass++;
      n_chk++; if (RData !== m_rdata) $display("FAIL unmapped_rand_rdata %h: got %h want %h", a, RData, m_rdata); else n_pass++;
      n_chk++; if (ctrl !== m_ctrl) $display("FAIL unmapped_rand_ctrl: got %h want %h", ctrl, m_ctrl); else n_pass++;
      cycle(1'b1, 1'b0, 8'h23, $urandom, 1'b0);
      n_chk++; if (bad_addr !== 1'b0) $display("FAIL unmapped_rand_clear: got %b want 0", bad_addr); else n_pass++;
    end
  endtask

  task automatic test_wrcnt();
`ifdef TDC_LBUS_WRCNT_EN
    cycle(1'b1, 1'b0, 8'h22, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'($urandom_range(0, NCTRL - 1)), $urandom, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'd3) $display("FAIL wrcnt_three: got %h want 3", RData); else n_pass++;
    cycle(1'b1, 1'b0, 8'h22, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'h0) $display("FAIL wrcnt_clear: got %h want 0", RData); else n_pass++;
    n_chk++; if (bad_addr !== m_bad) $display("FAIL wrcnt_bad: got %b want %b", bad_addr, m_bad); else n_pass++;
`else
    cycle(1'b1, 1'b0, 8'h23, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'hDEAD_BEEF) $display("FAIL wrcnt_absent_read: got %h want deadbeef", RData); else n_pass++;
    n_chk++; if (bad_addr !== 1'b1) $display("FAIL wrcnt_absent_bad: got %b want 1", bad_addr); else n_pass++;
    cycle(1'b1, 1'b0, 8'h23, 32'h0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] pool [7];
    pool = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h3F, 8'h47};
    for (int i = 0; i < 300; i++) begin
      next_status = $urandom;
      case ($urandom_range(0, 2))
        0: a = 8'($urandom_range(0, NCTRL - 1));
        1: a = pool[$urandom_range(0, 6)];
        default: a = 8'($urandom_range(0, 63));
      endcase
      cycle(1'($urandom), 1'($urandom), a, $urandom, ($urandom_range(0, 3) != 0));
      n_chk++; if (RData !== m_rdata) $display("FAIL b2b_rdata cyc%0d a=%h: got %h want %h", i, a, RData, m_rdata); else n_pass++;
      n_chk++; if (pulse !== m_pulse) $display("FAIL b2b_pulse cyc%0d: got %h want %h", i, pulse, m_pulse); else n_pass++;
      n_chk++; if (bad_addr !== m_bad) $display("FAIL b2b_bad cyc%0d: got %b want %b", i, bad_addr, m_bad); else n_pass++;
      n_chk++; if (ctrl !== m_ctrl) $display("FAIL b2b_ctrl cyc%0d: got %h want %h", i, ctrl, m_ctrl); else n_pass++;
    end
    // Same-cycle read and write returns the old contents
    cycle(1'b1, 1'b0, 8'h02, 32'h1111_2222, 1'b0);
    cycle(1'b1, 1'b1, 8'h02, 32'h3333_4444, 1'b0);
    n_chk++; if (RData !== 32'h1111_2222) $display("FAIL rw_same_cycle: got %h want 11112222", RData); else n_pass++;
    cycle(1'b0, 1'b1, 8'h02, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'h3333_4444) $display("FAIL rw_same_cycle_after: got %h want 33334444", RData); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(i), $urandom | 32'h1, 1'b1);
    cycle(1'b0, 1'b1, 8'h77, 32'h0, 1'b1);
    apply_reset(1);
    n_chk++; if (ctrl !== '0) $display("FAIL midreset_ctrl: got %h want 0", ctrl); else n_pass++;
    n_chk++; if (RData !== 32'h0) $display("FAIL midreset_rdata: got %h want 0", RData); else n_pass++;
    n_chk++; if (pulse !== 32'h0) $display("FAIL midreset_pulse: got %h want 0", pulse); else n_pass++;
    n_chk++; if (bad_addr !== 1'b0) $display("FAIL midreset_bad: got %b want 0", bad_addr); else n_pass++;
    cycle(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
    n_chk++; if (RData !== 32'h0) $display("FAIL midreset_evt: got %h want 0", RData); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ctrl();
    test_pulse();
    test_counter();
    test_status();
    test_unmapped();
    test_wrcnt();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
